// File: rtl/wash_seq_pkg.sv
// Shared state codes and defaults for the wash phase timer and its tick counters.
package wash_seq_pkg;

  localparam int DEFAULT_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WASH_ARM  = 3'd1,
    ST_WASH      = 3'd2,
    ST_RINSE_ARM = 3'd3,
    ST_RINSE     = 3'd4,
    ST_SPIN_ARM  = 3'd5,
    ST_SPIN      = 3'd6,
    ST_FAULT     = 3'd7
  } phase_e;

  // States in which the phase counter consumes motor ticks.
  function automatic logic is_count_state(input phase_e s);
    return (s == ST_WASH) || (s == ST_RINSE) || (s == ST_SPIN);
  endfunction

endpackage

// File: rtl/wash_tick_counter.sv
// Loadable down-counter that stops at zero; expire flags the edge on which it reaches zero.
module wash_tick_counter
  import wash_seq_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero   = (count == '0);
  assign expire = en && !load && (count == CNT_W'(1));

endmodule

// File: rtl/wash_phase_timer.sv
// Phase timer beside the washing-machine FSM: generates cycle/spin timeouts from programmed
// tick counts. Define WASH_PHASE_WATCHDOG_EN to build the stuck-drain watchdog (FAULT state).
module wash_phase_timer
  import wash_seq_pkg::*;
#(
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int DRAIN_LIMIT = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             prog_valid,
  output logic             prog_ready,
  input  logic [CNT_W-1:0] prog_wash_ticks,
  input  logic [CNT_W-1:0] prog_rinse_ticks,
  input  logic [CNT_W-1:0] prog_spin_ticks,
  input  logic             soap_wash,
  input  logic             water_wash,
  input  logic             motor_on,
  input  logic             drain_value_on,
  input  logic             done,
  output logic             cycle_timeout,
  output logic             spin_timeout,
  output logic             busy,
  output logic [2:0]       phase,
  output logic             fault
);

  phase_e           state;
  logic [CNT_W-1:0] wash_ticks;
  logic [CNT_W-1:0] rinse_ticks;
  logic [CNT_W-1:0] spin_ticks;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_en;
  logic             cnt_zero;
  logic             cnt_expire;
  logic             watch_trip;

  function automatic logic [CNT_W-1:0] clamp_ticks(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  // The arm states load the counter on the same edge that enters the counting state.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state)
      ST_WASH_ARM: begin
        cnt_load     = soap_wash;
        cnt_load_val = wash_ticks;
      end
      ST_RINSE_ARM: begin
        cnt_load     = water_wash;
        cnt_load_val = rinse_ticks;
      end
      ST_SPIN_ARM: begin
        cnt_load     = motor_on && drain_value_on;
        cnt_load_val = spin_ticks;
      end
      default: ;
    endcase
  end

  assign cnt_en = is_count_state(state) && motor_on && !cnt_zero;

  wash_tick_counter #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .zero     (cnt_zero),
    .expire   (cnt_expire)
  );

`ifdef WASH_PHASE_WATCHDOG_EN
  logic watch_cond;
  logic watch_zero;

  // Counter is reloaded whenever the drain-without-motor streak breaks.
  assign watch_cond = (state != ST_IDLE) && (state != ST_SPIN) && (state != ST_FAULT)
                      && drain_value_on && !motor_on;

  wash_tick_counter #(.CNT_W(CNT_W)) u_watch_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (!watch_cond),
    .load_val (CNT_W'(DRAIN_LIMIT)),
    .en       (watch_cond && !watch_zero),
    .zero     (watch_zero),
    .expire   (watch_trip)
  );

  assign fault = (state == ST_FAULT);
`else
  localparam int unused_drain_limit = DRAIN_LIMIT;
  assign watch_trip = 1'b0;
  assign fault      = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      wash_ticks    <= CNT_W'(1);
      rinse_ticks   <= CNT_W'(1);
      spin_ticks    <= CNT_W'(1);
      cycle_timeout <= 1'b0;
      spin_timeout  <= 1'b0;
    end else if (watch_trip) begin
      state         <= ST_FAULT;
      cycle_timeout <= 1'b0;
      spin_timeout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (prog_valid && prog_ready) begin
            wash_ticks  <= clamp_ticks(prog_wash_ticks);
            rinse_ticks <= clamp_ticks(prog_rinse_ticks);
            spin_ticks  <= clamp_ticks(prog_spin_ticks);
            state       <= ST_WASH_ARM;
          end
        end
        ST_WASH_ARM: begin
          if (soap_wash) state <= ST_WASH;
        end
        ST_WASH: begin
          if (!soap_wash) begin
            cycle_timeout <= 1'b0;
            state         <= ST_RINSE_ARM;
          end else if (cnt_expire) begin
            cycle_timeout <= 1'b1;
          end
        end
        ST_RINSE_ARM: begin
          if (water_wash) state <= ST_RINSE;
        end
        ST_RINSE: begin
          if (!water_wash) begin
            cycle_timeout <= 1'b0;
            state         <= ST_SPIN_ARM;
          end else if (cnt_expire) begin
            cycle_timeout <= 1'b1;
          end
        end
        ST_SPIN_ARM: begin
          if (motor_on && drain_value_on) state <= ST_SPIN;
        end
        ST_SPIN: begin
          if (done) begin
            spin_timeout <= 1'b0;
            state        <= ST_IDLE;
          end else if (cnt_expire) begin
            spin_timeout <= 1'b1;
          end
        end
        ST_FAULT: begin
          cycle_timeout <= 1'b0;
          spin_timeout  <= 1'b0;
        end
      endcase
    end
  end

  assign prog_ready = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign phase      = state;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Bench for wash_phase_timer: table vectors, hand-written corner sequences and random stimulus
// checked against a phase-level reference model.
module tb_wash_phase_timer;

  localparam int CNT_W = 16;
  localparam int LIMIT = 8;
`ifdef WASH_PHASE_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             prog_valid;
  logic             prog_ready;
  logic [CNT_W-1:0] w_ticks, r_ticks, s_ticks;
  logic             soap_wash, water_wash, motor_on, drain_value_on, done;
  logic             cycle_timeout, spin_timeout, busy, fault;
  logic [2:0]       phase;

  always #5 clk = ~clk;

  wash_phase_timer #(.CNT_W(CNT_W), .DRAIN_LIMIT(LIMIT)) dut (
    .clk              (clk),
    .reset            (reset),
    .prog_valid       (prog_valid),
    .prog_ready       (prog_ready),
    .prog_wash_ticks  (w_ticks),
    .prog_rinse_ticks (r_ticks),
    .prog_spin_ticks  (s_ticks),
    .soap_wash        (soap_wash),
    .water_wash       (water_wash),
    .motor_on         (motor_on),
    .drain_value_on   (drain_value_on),
    .done             (done),
    .cycle_timeout    (cycle_timeout),
    .spin_timeout     (spin_timeout),
    .busy             (busy),
    .phase            (phase),
    .fault            (fault)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase number, remaining ticks, programmed durations, drain streak.
  int m_state, m_left, m_streak;
  int m_dur[3];
  int m_cto, m_sto;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_left = 0; m_streak = 0;
    m_dur[0] = 1; m_dur[1] = 1; m_dur[2] = 1;
    m_cto = 0; m_sto = 0;
  endtask

  function automatic int at_least_one(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  // One clock edge of the phase rules, using the inputs as sampled on that edge.
  task automatic model_edge();
    int dur_idx;
    bit phase_in;
    if (WD_EN && m_state >= 1 && m_state <= 5 && drain_value_on && !motor_on)
      m_streak++;
    else
      m_streak = 0;
    if (m_streak >= LIMIT) begin
      m_state = 7; m_cto = 0; m_sto = 0; m_streak = 0;
      return;
    end
    dur_idx  = (m_state - 1) / 2;
    phase_in = (m_state <= 2) ? soap_wash : water_wash;
    if (m_state == 0) begin
      if (prog_valid) begin
        m_dur[0] = at_least_one(int'(w_ticks));
        m_dur[1] = at_least_one(int'(r_ticks));
        m_dur[2] = at_least_one(int'(s_ticks));
        m_state = 1;
      end
    end else if (m_state == 1 || m_state == 3) begin
      if (phase_in) begin m_left = m_dur[dur_idx]; m_state++; end
    end else if (m_state == 2 || m_state == 4) begin
      if (!phase_in) begin
        m_cto = 0; m_state++;
      end else if (motor_on && m_left > 0) begin
        m_left--;
        if (m_left == 0) m_cto = 1;
      end
    end else if (m_state == 5) begin
      if (motor_on && drain_value_on) begin m_left = m_dur[2]; m_state = 6; end
    end else if (m_state == 6) begin
      if (done) begin
        m_sto = 0; m_state = 0;
      end else if (motor_on && m_left > 0) begin
        m_left--;
        if (m_left == 0) m_sto = 1;
      end
    end
  endtask

  task automatic compare_model();
    check("phase", int'(phase), m_state);
    check("busy", int'(busy), int'(m_state != 0));
    check("prog_ready", int'(prog_ready), int'(m_state == 0));
    check("fault", int'(fault), int'(m_state == 7));
    check("cycle_timeout", int'(cycle_timeout), m_cto);
    check("spin_timeout", int'(spin_timeout), m_sto);
  endtask

  task automatic stp(input int pv, input int soap, input int water, input int motor,
                     input int drain, input int dn);
    prog_valid     = (pv != 0);
    soap_wash      = (soap != 0);
    water_wash     = (water != 0);
    motor_on       = (motor != 0);
    drain_value_on = (drain != 0);
    done           = (dn != 0);
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  // Asserted between edges so the asynchronous clear is observed before any clock.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_model();
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    int pv, soap, water, motor, drain, dn;
    int ph, cto, sto;
  } vec_t;

  vec_t tbl[21];

  initial begin
    reset = 1'b1;
    prog_valid = 0; soap_wash = 0; water_wash = 0; motor_on = 0; drain_value_on = 0; done = 0;
    w_ticks = '0; r_ticks = '0; s_ticks = '0;
    model_reset();
    #6;
    compare_model();
    check("reset_ready", int'(prog_ready), 1);
    @(negedge clk);
    reset = 1'b0;

    // Nominal run: wash=4, rinse=3, spin=5, motor held high.
    tbl = '{
      '{1,0,0,1,0,0, 1,0,0}, '{0,1,0,1,0,0, 2,0,0}, '{0,1,0,1,0,0, 2,0,0},
      '{0,1,0,1,0,0, 2,0,0}, '{0,1,0,1,0,0, 2,0,0}, '{0,1,0,1,0,0, 2,1,0},
      '{0,1,0,1,0,0, 2,1,0}, '{0,0,0,1,0,0, 3,0,0}, '{0,0,1,1,0,0, 4,0,0},
      '{0,0,1,1,0,0, 4,0,0}, '{0,0,1,1,0,0, 4,0,0}, '{0,0,1,1,0,0, 4,1,0},
      '{0,0,0,1,0,0, 5,0,0}, '{0,0,0,1,1,0, 6,0,0}, '{0,0,0,1,1,0, 6,0,0},
      '{0,0,0,1,1,0, 6,0,0}, '{0,0,0,1,1,0, 6,0,0}, '{0,0,0,1,1,0, 6,0,0},
      '{0,0,0,1,1,0, 6,0,1}, '{0,0,0,1,1,0, 6,0,1}, '{0,0,0,1,1,1, 0,0,0}
    };
    w_ticks = 16'd4; r_ticks = 16'd3; s_ticks = 16'd5;
    for (int i = 0; i < 21; i++) begin
      stp(tbl[i].pv, tbl[i].soap, tbl[i].water, tbl[i].motor, tbl[i].drain, tbl[i].dn);
      check("tbl_phase", int'(phase), tbl[i].ph);
      check("tbl_cycle_timeout", int'(cycle_timeout), tbl[i].cto);
      check("tbl_spin_timeout", int'(spin_timeout), tbl[i].sto);
      $display("vec %0d: phase=%0d cycle_timeout=%0b spin_timeout=%0b",
               i, phase, cycle_timeout, spin_timeout);
    end

    // Motor pause: two held edges stretch a 4-tick wash to 6 edges.
    w_ticks = 16'd4;
    stp(1,0,0,1,0,0);
    stp(0,1,0,1,0,0);
    stp(0,1,0,1,0,0);
    stp(0,1,0,0,0,0);
    stp(0,1,0,0,0,0);
    stp(0,1,0,1,0,0);
    stp(0,1,0,1,0,0);
    check("pause_edge5", int'(cycle_timeout), 0);
    stp(0,1,0,1,0,0);
    check("pause_edge6", int'(cycle_timeout), 1);
    do_reset();

    // Zero duration latches as 1; a mid-cycle reprogram is ignored.
    w_ticks = 16'd0; r_ticks = 16'd2; s_ticks = 16'd1;
    stp(1,0,0,1,0,0);
    stp(0,1,0,1,0,0);
    w_ticks = 16'd9; r_ticks = 16'd9;
    stp(1,1,0,1,0,0);
    check("zero_prog_timeout", int'(cycle_timeout), 1);
    check("ready_in_wash", int'(prog_ready), 0);
    stp(1,0,0,1,0,0);
    stp(0,0,1,1,0,0);
    stp(1,0,1,1,0,0);
    check("reprog_rinse_e1", int'(cycle_timeout), 0);
    stp(0,0,1,1,0,0);
    check("reprog_rinse_e2", int'(cycle_timeout), 1);
    do_reset();

    // Early phase exit after 2 of 10 ticks, then reset mid-SPIN.
    w_ticks = 16'd10; r_ticks = 16'd10; s_ticks = 16'd10;
    stp(1,0,0,1,0,0);
    stp(0,1,0,1,0,0);
    stp(0,1,0,1,0,0);
    stp(0,1,0,1,0,0);
    stp(0,0,0,1,0,0);
    check("early_exit_phase", int'(phase), 3);
    check("early_exit_timeout", int'(cycle_timeout), 0);
    stp(0,0,1,1,0,0);
    stp(0,0,0,1,0,0);
    stp(0,0,0,1,1,0);
    stp(0,0,0,1,1,0);
    check("in_spin", int'(phase), 6);
    do_reset();
    check("reset_phase", int'(phase), 0);
    check("reset_busy", int'(busy), 0);

    // Stuck drain in WASH_ARM.
    stp(1,0,0,1,0,0);
    for (int i = 1; i <= LIMIT; i++) begin
      stp(0,0,0,0,1,0);
      check("wd_phase", int'(phase), (i == LIMIT && WD_EN) ? 7 : 1);
      check("wd_fault", int'(fault), (i == LIMIT && WD_EN) ? 1 : 0);
    end
    stp(0,1,0,1,1,0);
    stp(1,0,1,1,0,1);
    check("wd_fault_held", int'(fault), WD_EN ? 1 : 0);
    do_reset();

    // Random stimulus against the reference model.
    for (int i = 0; i < 4000; i++) begin
      w_ticks = 16'($urandom_range(0, 6));
      r_ticks = 16'($urandom_range(0, 6));
      s_ticks = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        stp(int'($urandom_range(0, 3) == 0),
            (m_state <= 2) ? int'($urandom_range(0, 9) != 0) : int'($urandom_range(0, 3) == 0),
            (m_state == 3 || m_state == 4) ? int'($urandom_range(0, 9) != 0)
                                           : int'($urandom_range(0, 3) == 0),
            int'($urandom_range(0, 4) != 0),
            int'($urandom_range(0, 4) < 2),
            int'($urandom_range(0, 9) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
